// File: rtl/oam_dma_pkg.sv
// nes_dma_pkg: shared OAM DMA state enum and constants; ALIGN exists only with OAM_DMA_ALIGN_EN.
package nes_dma_pkg;
  localparam logic [15:0] DMA_REG_ADDR = 16'h4014;
  localparam int OAM_LEN = 256;
  typedef enum logic [2:0] {
    IDLE,
    HALT,
`ifdef OAM_DMA_ALIGN_EN
    ALIGN,
`endif
    READ,
    WRITE
  } state_e;
endpackage

// File: rtl/oam_dma_if.sv
// oam_dma_if: CPU trigger port, RAM read bus and OAM write port of the sprite DMA engine.
interface oam_dma_if;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_we;
  logic        cpu_halt;
  logic        mem_grant;
  logic [15:0] mem_addr;
  logic        mem_cs_n;
  logic        mem_rw_n;
  logic [7:0]  mem_rdata;
  logic [7:0]  oam_addr;
  logic [7:0]  oam_wdata;
  logic        oam_we;
  logic        dma_done;
  modport master (
    input  cpu_addr, cpu_wdata, cpu_we, mem_rdata,
    output cpu_halt, mem_grant, mem_addr, mem_cs_n, mem_rw_n, oam_addr, oam_wdata, oam_we, dma_done
  );
  modport slave (
    output cpu_addr, cpu_wdata, cpu_we, mem_rdata,
    input  cpu_halt, mem_grant, mem_addr, mem_cs_n, mem_rw_n, oam_addr, oam_wdata, oam_we, dma_done
  );
endinterface

// File: rtl/oam_dma.sv
// oam_dma: halts the CPU and copies one 256-byte RAM page into OAM; OAM_DMA_ALIGN_EN adds a phase-align cycle.
module oam_dma #(
  parameter logic [15:0] DMA_REG_ADDR = nes_dma_pkg::DMA_REG_ADDR,
  parameter int          XFER_LEN     = nes_dma_pkg::OAM_LEN
) (
  input logic      clk,
  input logic      rst,
  oam_dma_if.master bus
);
  import nes_dma_pkg::*;
  state_e     state_q, state_d;
  logic [7:0] page_q, page_d, idx_q, idx_d;
  logic       done_q, done_d;
  logic       trig, last, rd, wr;
`ifdef OAM_DMA_ALIGN_EN
  logic       phase_q, phase_d;
`endif
  assign trig = bus.cpu_we && bus.cpu_addr == DMA_REG_ADDR;
  assign last = idx_q == 8'(XFER_LEN - 1);
  assign rd   = state_q == READ;
  assign wr   = state_q == WRITE;
  always_comb begin
    state_d = state_q;
    page_d  = page_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
`ifdef OAM_DMA_ALIGN_EN
    phase_d = ~phase_q;
`endif
    case (state_q)
      IDLE: if (trig) begin
        state_d = HALT;
        page_d  = bus.cpu_wdata;
        idx_d   = '0;
      end
`ifdef OAM_DMA_ALIGN_EN
      // phase 0 here means the trigger landed on phase 1; one extra cycle puts reads on even phase
      HALT:  state_d = phase_q ? READ : ALIGN;
      ALIGN: state_d = READ;
`else
      HALT:  state_d = READ;
`endif
      READ:  state_d = WRITE;
      WRITE: begin
        idx_d   = idx_q + 8'd1;
        state_d = last ? IDLE : READ;
        done_d  = last;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      page_q  <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
`ifdef OAM_DMA_ALIGN_EN
      phase_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      page_q  <= page_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
`ifdef OAM_DMA_ALIGN_EN
      phase_q <= phase_d;
`endif
    end
  end
  assign bus.cpu_halt  = state_q != IDLE;
  assign bus.mem_grant = state_q != IDLE;
  assign bus.mem_addr  = rd ? {page_q, idx_q} : '0;
  assign bus.mem_cs_n  = ~rd;
  assign bus.mem_rw_n  = 1'b1;
  assign bus.oam_we    = wr;
  assign bus.oam_addr  = wr ? idx_q : '0;
  assign bus.oam_wdata = wr ? bus.mem_rdata : '0;
  assign bus.dma_done  = done_q;
endmodule

// File: tb/tb_oam_dma.sv
// tb_oam_dma: scoreboard bench for oam_dma; expected OAM bytes are queued at trigger time from the RAM model.
module tb_oam_dma;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  oam_dma_if bus();
  oam_dma dut (.clk(clk), .rst(rst), .bus(bus));
  logic [7:0]  ram [0:65535];
  logic [15:0] sb_q [$];
  logic [15:0] e;
  int n_chk = 0, n_err = 0, cyc = 0, trig_cyc = 0, exp_len = 513, n_done = 0, n_oam = 0;
  int nd, no;
  logic ph = 1'b0;
  logic [7:0] cur_page = 8'h00, last_addr = 8'h00, last_data = 8'h00;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h want %0h", tag, got, exp);
    end
  endtask
  always @(posedge clk) begin
    cyc <= cyc + 1;
    ph  <= rst ? 1'b0 : ~ph;
    if (!bus.mem_cs_n) bus.mem_rdata <= ram[bus.mem_addr];
  end
  always @(negedge clk) if (!rst) begin
    if (bus.dma_done) n_done++;
    if (!bus.mem_cs_n) chk("rd_page", {24'd0, bus.mem_addr[15:8]}, {24'd0, cur_page});
    if (bus.oam_we) begin
      n_oam++;
      last_addr = bus.oam_addr;
      last_data = bus.oam_wdata;
      if (sb_q.size() == 0) chk("oam_unexp", 1, 0);
      else begin
        e = sb_q.pop_front();
        chk("oam_addr", {24'd0, bus.oam_addr}, {24'd0, e[15:8]});
        chk("oam_data", {24'd0, bus.oam_wdata}, {24'd0, e[7:0]});
      end
    end
  end
  task automatic poke(input logic [15:0] a, input logic [7:0] d);
    bus.cpu_addr  = a;
    bus.cpu_wdata = d;
    bus.cpu_we    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.cpu_we = 1'b0;
  endtask
  task automatic trigger(input logic [7:0] p);
    exp_len = 513;
`ifdef OAM_DMA_ALIGN_EN
    if (ph) exp_len = 514;
`endif
    for (int i = 0; i < 256; i++) sb_q.push_back({8'(i), ram[{p, 8'(i)}]});
    cur_page = p;
    poke(16'h4014, p);
    trig_cyc = cyc;
  endtask
  task automatic wait_done();
    int k = 0;
    while (!bus.dma_done && k < 700) begin
      @(negedge clk);
      k++;
    end
    chk("done_seen", {31'd0, bus.dma_done}, 1);
    chk("done_len", cyc - trig_cyc, exp_len);
    chk("sb_empty", sb_q.size(), 0);
  endtask
  initial begin
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    bus.cpu_we    = 1'b0;
    for (int a = 0; a < 65536; a++) ram[a] = 8'(a ^ (a >> 8));
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_halt", {31'd0, bus.cpu_halt}, 0);
    chk("rst_grant", {31'd0, bus.mem_grant}, 0);
    chk("rst_cs_n", {31'd0, bus.mem_cs_n}, 1);
    chk("rst_rw_n", {31'd0, bus.mem_rw_n}, 1);
    chk("rst_oam_we", {31'd0, bus.oam_we}, 0);
    chk("rst_done", {31'd0, bus.dma_done}, 0);
    chk("rst_mem_addr", {16'd0, bus.mem_addr}, 0);
    rst = 1'b0;
    for (int i = 0; i < 256; i++) ram[16'h0600 + i] = 8'(i);
    poke(16'h4015, 8'h06);
    chk("wrong_addr_halt", {31'd0, bus.cpu_halt}, 0);
    trigger(8'h06);
    chk("halt_hi", {31'd0, bus.cpu_halt}, 1);
    chk("grant_hi", {31'd0, bus.mem_grant}, 1);
    chk("halt_cs_n", {31'd0, bus.mem_cs_n}, 1);
    wait_done();
    ram[16'hFFFF] = 8'hA5;
    trigger(8'hFF);
    chk("b2b_halt", {31'd0, bus.cpu_halt}, 1);
    wait_done();
    chk("ff_last_addr", {24'd0, last_addr}, 32'hFF);
    chk("ff_last_data", {24'd0, last_data}, 32'hA5);
    @(negedge clk);
    chk("done_pulse_end", {31'd0, bus.dma_done}, 0);
    chk("idle_halt", {31'd0, bus.cpu_halt}, 0);
    for (int i = 0; i < 256; i++) begin
      ram[16'h0200 + i] = ~8'(i);
      ram[16'h0300 + i] = 8'(i) ^ 8'h3C;
    end
    trigger(8'h02);
    repeat (100) @(negedge clk);
    poke(16'h4014, 8'h03);
    wait_done();
    for (int w = 0; w < 2; w++) begin
      @(negedge clk);
      if (ph != w[0]) @(negedge clk);
      trigger(8'h01);
      wait_done();
    end
    @(negedge clk);
    trigger(8'h04);
    repeat (299) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_halt", {31'd0, bus.cpu_halt}, 0);
    chk("abort_grant", {31'd0, bus.mem_grant}, 0);
    chk("abort_cs_n", {31'd0, bus.mem_cs_n}, 1);
    chk("abort_oam_we", {31'd0, bus.oam_we}, 0);
    rst = 1'b0;
    sb_q.delete();
    nd = n_done;
    no = n_oam;
    repeat (600) @(negedge clk);
    chk("abort_no_done", n_done, nd);
    chk("abort_no_oam", n_oam, no);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
